mutex_requester_5: RTL and testbench
====================================

# mutex_requester_5

Synchronous client-side front end for the five-way mutex arbiter. Five independent clocked channels each request exclusive access through the asynchronous arbiter's request inputs (X4..X0) and receive its grant outputs (Y4..Y0). The block drives requests, synchronises grants, holds each granted access for a programmed number of cycles, and completes the four-phase return-to-zero handshake. It also flags any mutual-exclusion or protocol violation seen at the arbiter.

## Interface
- SYNC_STAGES, 2: flip-flop depth of each grant synchroniser (≥2).
- HOLD_W, 8: width of each per-channel hold length.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  reset; asynchronous assert, active-low.
- START  in  5  per-channel one-cycle start strobe; bit i = channel i.
- HOLD_LEN  in  5*HOLD_W  channel i hold length in bits [i*HOLD_W +: HOLD_W]; sampled on accepted START.
- CLR_ERR  in  1  synchronous clear of the sticky error flags.
- REQ  out  5  registered requests to the arbiter; REQ[i] drives Xi.
- GNT  in  5  asynchronous grants from the arbiter; GNT[i] from Yi.
- BUSY  out  5  channel i not IDLE.
- DONE  out  5  one-cycle pulse when channel i completes.
- OWNER  out  3  index of the channel in HOLD; 3'd7 when none.
- ERR_MULTI  out  1  sticky: more than one synchronised grant high.
- ERR_PROTO  out  1  sticky: synchronised grant high while its channel is IDLE.

## Operation
- Per-channel FSM: IDLE, WAIT, HOLD, REL.
- IDLE: REQ=0. START[i]=1 → WAIT; latch HOLD_LEN slice (0 is treated as 1).
- WAIT: REQ=1. Synchronised grant gs[i]=1 → HOLD; load counter with the latched length.
- HOLD: REQ=1; counter decrements each cycle. On the last hold cycle the FSM moves to REL.
- REL: REQ=0. When gs[i]=0, the FSM moves to IDLE and pulses DONE[i].
- START[i] outside IDLE is ignored; it is neither queued nor an error.
- REQ is never dropped in WAIT. A request is never withdrawn before grant, so the mutex never sees a withdrawn contention.
- OWNER is the lowest index in HOLD. With a correct arbiter at most one channel is in HOLD.
- ERR_MULTI sets when popcount(gs) > 1 in any cycle. ERR_PROTO sets when gs[i]=1 while channel i is IDLE.
- Both error flags hold until CLR_ERR=1 or reset. If CLR_ERR and a new error occur in the same cycle, the set wins.
- Channels run fully independently. Simultaneous STARTs all enter WAIT, and the arbiter decides the order.

## Timing
- Reset (async, RST_N=0): all FSMs IDLE; REQ=0, BUSY=0, DONE=0, OWNER=7, ERR_*=0, synchronisers cleared.
- Reset mid-operation drops REQ immediately, which releases the arbiter. Channels restart only on a new START after RST_N deasserts.
- Edge e0 samples START[i]=1: after e0, REQ[i]=1 and BUSY[i]=1.
- Grant visibility: GNT rising between e(k) and e(k+1) is seen by the FSM at edge e(k+1+SYNC_STAGES).
- HOLD lasts exactly H cycles, where H is the latched HOLD_LEN (min 1). REQ falls at the edge ending the last HOLD cycle.
- Uncontended START-to-DONE, with GNT following REQ combinationally: DONE is high in the cycle after edge e0+2*SYNC_STAGES+H+2. For SYNC_STAGES=2, H=4, that edge is e10.
- After DONE, a START in the same cycle is accepted. Back-to-back minimum gap is 0 idle cycles after DONE.
- Contention: the loser stays in WAIT with REQ=1 until the winner's REL drops the grant and the arbiter regrants.

## Test plan
- Single channel: reset, START[2]=1, HOLD_LEN[2]=4, GNT mirrors REQ → REQ[2] high e1..e7; OWNER=2 for 4 cycles; DONE[2] pulse after edge e10; BUSY[2] low again the same cycle.
- Contention: START[4] and START[0] in the same cycle, HOLD=3, behavioural mutex grants 4 first → channel 0 enters HOLD only after channel 4's DONE; OWNER sequence 4,7,…,0; ERR_MULTI stays 0.
- All five channels start together, HOLD=1 → five DONE pulses, all distinct cycles; no error flags.
- Fault injection: force GNT=5'b00011 while both channels are in WAIT → ERR_MULTI=1 after SYNC_STAGES+1 edges; stays 1 until CLR_ERR, then 0.
- Protocol fault: GNT[3]=1 with channel 3 IDLE → ERR_PROTO=1. START during HOLD is ignored, so DONE count=1. HOLD_LEN=0 behaves as 1.
- Reset mid-HOLD: assert RST_N=0 → REQ=0 immediately and outputs return to reset values. After release, a new START completes normally.

Source files
------------

// File: rtl/mutex_requester_5.sv
// mutex_requester_5: synchronous five-channel client for the async mutex arbiter.
// Drives requests, synchronises grants, times each hold and flags exclusion faults.
module mutex_requester_5 #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_W      = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [4:0]          START,
    input  logic [5*HOLD_W-1:0] HOLD_LEN,
    input  logic                CLR_ERR,
    output logic [4:0]          REQ,
    input  logic [4:0]          GNT,
    output logic [4:0]          BUSY,
    output logic [4:0]          DONE,
    output logic [2:0]          OWNER,
    output logic                ERR_MULTI,
    output logic                ERR_PROTO
);
    typedef enum logic [1:0] {IDLE, WAIT, HOLD, REL} state_e;

    state_e            state_q [5];
    state_e            state_d [5];
    logic [HOLD_W-1:0] len_q   [5];
    logic [HOLD_W-1:0] len_d   [5];
    logic [HOLD_W-1:0] cnt_q   [5];
    logic [HOLD_W-1:0] cnt_d   [5];
    logic [HOLD_W-1:0] slice;

    logic [SYNC_STAGES-1:0][4:0] sync_q;
    logic [4:0] gs;
    logic [4:0] idle_m;
    logic [4:0] req_d, req_q;
    logic [4:0] done_d, done_q;
    logic       err_multi_d, err_multi_q;
    logic       err_proto_d, err_proto_q;

    assign gs = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 5; i++) begin
                state_q[i] <= IDLE;
                len_q[i]   <= '0;
                cnt_q[i]   <= '0;
            end
            sync_q      <= '0;
            req_q       <= '0;
            done_q      <= '0;
            err_multi_q <= 1'b0;
            err_proto_q <= 1'b0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                state_q[i] <= state_d[i];
                len_q[i]   <= len_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            sync_q      <= {sync_q[SYNC_STAGES-2:0], GNT};
            req_q       <= req_d;
            done_q      <= done_d;
            err_multi_q <= err_multi_d;
            err_proto_q <= err_proto_d;
        end
    end

    // REQ is registered from the next state so it never glitches toward the mutex
    always_comb begin
        req_d  = '0;
        done_d = '0;
        idle_m = '0;
        slice  = '0;
        for (int i = 0; i < 5; i++) begin
            state_d[i] = state_q[i];
            len_d[i]   = len_q[i];
            cnt_d[i]   = cnt_q[i];
            idle_m[i]  = (state_q[i] == IDLE);
            slice      = HOLD_LEN[i*HOLD_W +: HOLD_W];
            unique case (state_q[i])
                IDLE: begin
                    if (START[i]) begin
                        state_d[i] = WAIT;
                        len_d[i]   = (slice == '0) ? HOLD_W'(1) : slice;
                    end
                end
                WAIT: begin
                    if (gs[i]) begin
                        state_d[i] = HOLD;
                        cnt_d[i]   = len_q[i];
                    end
                end
                HOLD: begin
                    cnt_d[i] = cnt_q[i] - HOLD_W'(1);
                    if (cnt_q[i] == HOLD_W'(1)) begin
                        state_d[i] = REL;
                    end
                end
                REL: begin
                    if (!gs[i]) begin
                        state_d[i] = IDLE;
                        done_d[i]  = 1'b1;
                    end
                end
                default: ;
            endcase
            req_d[i] = (state_d[i] == WAIT) || (state_d[i] == HOLD);
        end
    end

    // a new error in the same cycle as CLR_ERR keeps the flag set
    always_comb begin
        err_multi_d = (|(gs & (gs - 5'd1))) | (err_multi_q & ~CLR_ERR);
        err_proto_d = (|(gs & idle_m)) | (err_proto_q & ~CLR_ERR);
    end

    always_comb begin
        OWNER = 3'd7;
        for (int i = 4; i >= 0; i--) begin
            if (state_q[i] == HOLD) begin
                OWNER = 3'(i);
            end
        end
    end

    assign REQ       = req_q;
    assign BUSY      = ~idle_m;
    assign DONE      = done_q;
    assign ERR_MULTI = err_multi_q;
    assign ERR_PROTO = err_proto_q;
endmodule

// File: tb/tb_mutex_requester_5.sv
// tb_mutex_requester_5: behavioural mutex, transaction-level reference model,
// DONE scoreboard with a decoupled monitor, directed and random stimulus.
module tb_mutex_requester_5;
    localparam int S  = 2;
    localparam int HW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [4:0]      start = '0;
    logic [5*HW-1:0] hold_len = '0;
    logic            clr_err = 1'b0;
    logic [4:0]      req, busy, done;
    logic [4:0]      gnt = '0;
    logic [2:0]      owner;
    logic            err_multi, err_proto;

    logic       force_en = 1'b0;
    logic [4:0] force_val = '0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct { int ch; int at; } ev_t;
    ev_t sb[$];

    bit   m_act [5];
    bit   m_wait[5];
    bit   m_hold[5];
    int   m_len [5];
    int   m_rem [5];
    logic [4:0] m_g1 = '0, m_g2 = '0;
    bit   m_emulti = 0, m_eproto = 0;

    mutex_requester_5 #(.SYNC_STAGES(S), .HOLD_W(HW)) dut (
        .CLK(clk), .RST_N(rst_n), .START(start), .HOLD_LEN(hold_len),
        .CLR_ERR(clr_err), .REQ(req), .GNT(gnt), .BUSY(busy), .DONE(done),
        .OWNER(owner), .ERR_MULTI(err_multi), .ERR_PROTO(err_proto)
    );

    always #5 clk = ~clk;

    // behavioural mutex: free grant goes to highest requester, held until its REQ drops
    int mx = -1;
    always @(req or force_en or force_val) begin
        if (mx >= 0 && !req[mx]) mx = -1;
        if (mx < 0)
            for (int i = 4; i >= 0; i--)
                if (mx < 0 && req[i] === 1'b1) mx = i;
        gnt = force_en ? force_val : (mx >= 0 ? 5'(1 << mx) : 5'd0);
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit any_act();
        bit a = 0;
        for (int i = 0; i < 5; i++) a |= m_act[i];
        return a;
    endfunction

    function automatic logic [4:0] exp_req();
        logic [4:0] r = '0;
        for (int i = 0; i < 5; i++) r[i] = m_act[i] && (m_wait[i] || m_hold[i]);
        return r;
    endfunction

    function automatic logic [4:0] exp_busy();
        logic [4:0] r = '0;
        for (int i = 0; i < 5; i++) r[i] = m_act[i];
        return r;
    endfunction

    function automatic logic [2:0] exp_owner();
        for (int i = 0; i < 5; i++) if (m_hold[i]) return 3'(i);
        return 3'd7;
    endfunction

    task automatic model_step();
        logic [4:0] gs;
        bit mset, pset;
        ev_t e;
        cyc++;
        gs = m_g2;
        m_g2 = m_g1;
        m_g1 = gnt;
        mset = $countones(gs) > 1;
        pset = 0;
        for (int i = 0; i < 5; i++) if (gs[i] && !m_act[i]) pset = 1;
        for (int i = 0; i < 5; i++) begin
            if (!m_act[i]) begin
                if (start[i]) begin
                    m_act[i] = 1; m_wait[i] = 1; m_hold[i] = 0;
                    m_len[i] = int'(hold_len[i*HW +: HW]);
                    if (m_len[i] == 0) m_len[i] = 1;
                end
            end else if (m_wait[i]) begin
                if (gs[i]) begin
                    m_wait[i] = 0; m_hold[i] = 1; m_rem[i] = m_len[i];
                end
            end else if (m_hold[i]) begin
                m_rem[i]--;
                if (m_rem[i] == 0) m_hold[i] = 0;
            end else if (!gs[i]) begin
                m_act[i] = 0;
                e.ch = i; e.at = cyc;
                sb.push_back(e);
            end
        end
        m_emulti = mset || (m_emulti && !clr_err);
        m_eproto = pset || (m_eproto && !clr_err);
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) begin
                m_act[i] = 0; m_wait[i] = 0; m_hold[i] = 0;
            end
            m_g1 = '0; m_g2 = '0; m_emulti = 0; m_eproto = 0;
            sb.delete();
        end else begin
            model_step();
        end
    end

    initial forever begin
        ev_t e;
        @(negedge clk);
        check("req", req, exp_req());
        check("busy", busy, exp_busy());
        check("owner", owner, exp_owner());
        check("err_multi", err_multi, m_emulti);
        check("err_proto", err_proto, m_eproto);
        while (sb.size() > 0 && sb[0].at < cyc) begin
            e = sb.pop_front();
            check($sformatf("done_missing_ch%0d", e.ch), 0, 1);
        end
        for (int i = 0; i < 5; i++) begin
            if (done[i]) begin
                if (sb.size() == 0) begin
                    check($sformatf("done_unexpected_ch%0d", i), 1, 0);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("done_ch%0d", i), i, e.ch);
                    check($sformatf("done_cycle_ch%0d", i), cyc, e.at);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_len(int ch, int v);
        hold_len[ch*HW +: HW] = HW'(v);
    endtask

    task automatic wait_idle(int bound, string name);
        int n = 0;
        while ((any_act() || sb.size() > 0) && n < bound) begin
            tick();
            n++;
        end
        check({"idle_", name}, n < bound, 1);
    endtask

    initial begin
        int t0, dat, nreq, nown, nd, clash, p, d4, f0;
        bit bz;
        int seq[$];

        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_req", req, 0);
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 7);
        check("rst_errs", {err_multi, err_proto}, 0);

        // single channel, H=4
        set_len(2, 4);
        start = 5'b00100;
        t0 = cyc + 1;
        tick();
        start = '0;
        nreq = 0; nown = 0; dat = -1; bz = 1;
        for (int k = 0; k < 20; k++) begin
            if (req[2]) nreq++;
            if (owner == 3'd2) nown++;
            if (done[2]) begin dat = cyc; bz = busy[2]; end
            tick();
        end
        check("single_latency", dat - t0, 10);
        check("single_req_cycles", nreq, 7);
        check("single_owner_cycles", nown, 4);
        check("single_busy_at_done", bz, 0);
        wait_idle(50, "single");

        // contention between 4 and 0
        set_len(4, 3); set_len(0, 3);
        start = 5'b10001;
        tick();
        start = '0;
        p = 7; d4 = -1; f0 = -1;
        for (int k = 0; k < 40; k++) begin
            if (int'(owner) != p) begin seq.push_back(int'(owner)); p = int'(owner); end
            if (done[4] && d4 < 0) d4 = cyc;
            if (owner == 3'd0 && f0 < 0) f0 = cyc;
            tick();
        end
        check("cont_seq0", seq.size() > 0 ? seq[0] : 99, 4);
        check("cont_seq1", seq.size() > 1 ? seq[1] : 99, 7);
        check("cont_seq2", seq.size() > 2 ? seq[2] : 99, 0);
        check("cont_order", d4 >= 0 && f0 >= d4, 1);
        check("cont_no_multi", err_multi, 0);
        wait_idle(50, "cont");

        // all five, H=1
        for (int i = 0; i < 5; i++) set_len(i, 1);
        start = 5'h1f;
        tick();
        start = '0;
        nd = 0; clash = 0;
        for (int k = 0; k < 60; k++) begin
            nd += $countones(done);
            if ($countones(done) > 1) clash++;
            tick();
        end
        check("all5_dones", nd, 5);
        check("all5_distinct", clash, 0);
        check("all5_errs", {err_multi, err_proto}, 0);
        wait_idle(50, "all5");

        // double grant while 0 and 1 wait
        force_en = 1'b1; force_val = '0;
        set_len(0, 2); set_len(1, 2);
        start = 5'b00011;
        tick();
        start = '0;
        tick(); tick();
        force_val = 5'b00011;
        tick(); check("multi_e1", err_multi, 0);
        tick(); check("multi_e2", err_multi, 0);
        tick(); check("multi_e3", err_multi, 1);
        repeat (6) tick();
        force_val = '0;
        repeat (6) tick();
        check("multi_sticky", err_multi, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("multi_clr", err_multi, 0);
        force_en = 1'b0;
        wait_idle(50, "multi");

        // grant to an idle channel, then set-wins-over-clear
        force_en = 1'b1; force_val = 5'b01000;
        tick();
        force_val = '0;
        repeat (4) tick();
        check("proto_set", err_proto, 1);
        check("proto_no_multi", err_multi, 0);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        check("proto_clr", err_proto, 0);
        force_val = 5'b01000;
        tick();
        force_val = '0;
        tick();
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        check("proto_set_wins", err_proto, 1);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        check("proto_clr2", err_proto, 0);
        force_en = 1'b0;
        tick();

        // START during WAIT/HOLD/REL ignored
        set_len(1, 5);
        start = 5'b00010;
        tick();
        start = '0;
        nd = 0;
        for (int k = 0; k < 30; k++) begin
            if (done[1]) nd++;
            start = (k >= 2 && k < 9) ? 5'b00010 : 5'b00000;
            tick();
        end
        start = '0;
        check("start_ignored_dones", nd, 1);
        wait_idle(50, "ignored");

        // HOLD_LEN=0 behaves as 1
        set_len(3, 0);
        start = 5'b01000;
        tick();
        start = '0;
        nown = 0; nd = 0;
        for (int k = 0; k < 20; k++) begin
            if (owner == 3'd3) nown++;
            if (done[3]) nd++;
            tick();
        end
        check("len0_owner_cycles", nown, 1);
        check("len0_dones", nd, 1);
        wait_idle(50, "len0");

        // random traffic with one mid-run reset
        for (int k = 0; k < 400; k++) begin
            start = '0;
            if ($urandom_range(0, 3) == 0) start = 5'($urandom);
            for (int i = 0; i < 5; i++) set_len(i, int'($urandom_range(0, 6)));
            clr_err = ($urandom_range(0, 15) == 0);
            if (k == 200) begin
                #2 rst_n = 1'b0;
                #1 check("rand_rst_req", req, 0);
                tick();
                rst_n = 1'b1;
            end
            tick();
        end
        start = '0;
        clr_err = 1'b0;
        wait_idle(300, "rand");

        // reset in the middle of HOLD
        set_len(2, 10);
        start = 5'b00100;
        tick();
        start = '0;
        repeat (6) tick();
        check("pre_rst_owner", owner, 2);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_req", req, 0);
        check("midrst_busy", busy, 0);
        check("midrst_owner", owner, 7);
        check("midrst_done", done, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        set_len(2, 2);
        start = 5'b00100;
        t0 = cyc + 1;
        tick();
        start = '0;
        dat = -1;
        for (int k = 0; k < 20; k++) begin
            if (done[2]) dat = cyc;
            tick();
        end
        check("after_rst_latency", dat - t0, 8);
        wait_idle(50, "final");

        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
